// File: rtl/sc_downlifecounter.sv
// Lives-remaining counter for the Frogger core.
// Loads lives, deducts on hits with a grace window, adds bonus lives, flags game over.
module sc_downlifecounter #(
   parameter int DATAWIDTH    = 4,
   parameter int INIT_LIVES   = 3,
   parameter int MAX_LIVES    = 9,
   parameter int GRACE_CYCLES = 50_000_000,
   parameter int GRACE_WIDTH  = 26
) (
   input  logic                 SC_upLIFECOUNTER_CLOCK_50,
   input  logic                 SC_upLIFECOUNTER_RESET_InHigh,
   input  logic                 start_InLow,
   input  logic                 clear_InLow,
   input  logic                 hit_InLow,
   input  logic                 bonus_InLow,
   output logic [DATAWIDTH-1:0] lives_OutBUS,
   output logic                 grace_Out,
   output logic                 gameover_Out,
   output logic                 hitack_Out
);

   typedef enum logic [1:0] {
      IDLE,
      ALIVE,
      GRACE,
      GAMEOVER
   } state_t;

   localparam logic [DATAWIDTH-1:0]   INIT_L = DATAWIDTH'(INIT_LIVES);
   localparam logic [DATAWIDTH-1:0]   MAX_L  = DATAWIDTH'(MAX_LIVES);
   localparam logic [DATAWIDTH-1:0]   ONE_L  = DATAWIDTH'(1);
   localparam logic [GRACE_WIDTH-1:0] LOAD_T = GRACE_WIDTH'(GRACE_CYCLES - 1);
   localparam logic [GRACE_WIDTH-1:0] ONE_T  = GRACE_WIDTH'(1);

   state_t                 state;
   state_t                 stateNext;
   logic [DATAWIDTH-1:0]   lives;
   logic [DATAWIDTH-1:0]   livesNext;
   logic [GRACE_WIDTH-1:0] timer;
   logic [GRACE_WIDTH-1:0] timerNext;
   logic                   hitackNext;
   logic                   graceNext;
   logic                   gameoverNext;
   logic [DATAWIDTH-1:0]   livesUp;
   logic [DATAWIDTH-1:0]   livesHit;

   // Saturating increment and hit result (hit plus bonus in the same clock cancel out)
   always_comb begin
      livesUp = (lives >= MAX_L) ? MAX_L : lives + ONE_L;
      if (!bonus_InLow) begin
         livesHit = (lives > MAX_L) ? MAX_L : lives;
      end else begin
         livesHit = (lives == '0) ? '0 : lives - ONE_L;
      end
   end

   // State, lives, timer and registered outputs
   always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
      if (SC_upLIFECOUNTER_RESET_InHigh) begin
         state        <= IDLE;
         lives        <= '0;
         timer        <= '0;
         grace_Out    <= 1'b0;
         gameover_Out <= 1'b0;
         hitack_Out   <= 1'b0;
      end else begin
         state        <= stateNext;
         lives        <= livesNext;
         timer        <= timerNext;
         grace_Out    <= graceNext;
         gameover_Out <= gameoverNext;
         hitack_Out   <= hitackNext;
      end
   end

   // Next state, lives and timer with priority clear > start > hit/bonus
   always_comb begin
      stateNext  = state;
      livesNext  = lives;
      timerNext  = timer;
      hitackNext = 1'b0;
      if (!clear_InLow) begin
         stateNext = IDLE;
         livesNext = '0;
         timerNext = '0;
      end else if (!start_InLow) begin
         stateNext = ALIVE;
         livesNext = INIT_L;
         timerNext = '0;
      end else begin
         unique case (state)
            IDLE: begin
               livesNext = '0;
               timerNext = '0;
            end
            ALIVE: begin
               if (!hit_InLow) begin
                  livesNext  = livesHit;
                  hitackNext = 1'b1;
                  if (livesHit == '0) begin
                     stateNext = GAMEOVER;
                     timerNext = '0;
                  end else begin
                     stateNext = GRACE;
                     timerNext = LOAD_T;
                  end
               end else if (!bonus_InLow) begin
                  livesNext = livesUp;
               end
            end
            GRACE: begin
               if (!bonus_InLow) begin
                  livesNext = livesUp;
               end
               if (timer == '0) begin
                  stateNext = ALIVE;
               end else begin
                  timerNext = timer - ONE_T;
               end
            end
            GAMEOVER: begin
               livesNext = '0;
               timerNext = '0;
            end
            default: begin
               stateNext = IDLE;
               livesNext = '0;
               timerNext = '0;
            end
         endcase
      end
   end

   // Output flags decoded from the upcoming state
   always_comb begin
      graceNext    = (stateNext == GRACE);
      gameoverNext = (stateNext == GAMEOVER);
   end

   assign lives_OutBUS = lives;

endmodule

// File: tb/tb_sc_downlifecounter.sv
// Self-checking bench for sc_downlifecounter.
// Directed game scenarios plus random play against a behavioural model.
module tb_sc_downlifecounter;

   localparam int DW = 4;
   localparam int INIT = 3;
   localparam int MAXL = 9;
   localparam int G = 4;

   logic          clk;
   logic          rst;
   logic          startN;
   logic          clearN;
   logic          hitN;
   logic          bonusN;
   logic [DW-1:0] lives;
   logic          grace;
   logic          over;
   logic          ack;

   int checks = 0;
   int errors = 0;
   int ackCnt = 0;
   int cycNo = 0;
   int ackAt[$];

   // model: lives count, grace cycles left, playing flag, game-over flag
   int  mLives = 0;
   int  mGraceLeft = 0;
   bit  mPlay = 0;
   bit  mOver = 0;
   bit  mAck = 0;

   sc_downlifecounter #(
      .DATAWIDTH(DW),
      .INIT_LIVES(INIT),
      .MAX_LIVES(MAXL),
      .GRACE_CYCLES(G),
      .GRACE_WIDTH(3)
   ) dut (
      .SC_upLIFECOUNTER_CLOCK_50(clk),
      .SC_upLIFECOUNTER_RESET_InHigh(rst),
      .start_InLow(startN),
      .clear_InLow(clearN),
      .hit_InLow(hitN),
      .bonus_InLow(bonusN),
      .lives_OutBUS(lives),
      .grace_Out(grace),
      .gameover_Out(over),
      .hitack_Out(ack)
   );

   initial clk = 0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cycNo, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAXL) ? MAXL : v;
   endfunction

   task automatic modelReset();
      mLives = 0;
      mGraceLeft = 0;
      mPlay = 0;
      mOver = 0;
      mAck = 0;
   endtask

   task automatic modelStep(input bit s, input bit c, input bit h, input bit b);
      bit bon;
      bon = !b;
      mAck = 0;
      if (!c) begin
         modelReset();
      end else if (!s) begin
         mLives = INIT;
         mPlay = 1;
         mOver = 0;
         mGraceLeft = 0;
      end else if (mPlay) begin
         if (mGraceLeft > 0) begin
            mGraceLeft--;
            if (bon) mLives = sat(mLives + 1);
         end else if (!h) begin
            mLives = sat(mLives - 1 + (bon ? 1 : 0));
            mAck = 1;
            if (mLives == 0) begin
               mPlay = 0;
               mOver = 1;
            end else begin
               mGraceLeft = G;
            end
         end else if (bon) begin
            mLives = sat(mLives + 1);
         end
      end
   endtask

   task automatic checkOuts();
      chk("lives", int'(lives), mLives);
      chk("grace", int'(grace), int'(mGraceLeft > 0));
      chk("gameover", int'(over), int'(mOver));
      chk("hitack", int'(ack), int'(mAck));
   endtask

   task automatic cyc(input bit s, input bit c, input bit h, input bit b);
      startN = s;
      clearN = c;
      hitN = h;
      bonusN = b;
      @(posedge clk);
      cycNo++;
      modelStep(s, c, h, b);
      #1;
      checkOuts();
      if (ack === 1'b1) begin
         ackCnt++;
         ackAt.push_back(cycNo);
      end
   endtask

   initial begin
      rst = 1;
      startN = 1;
      clearN = 1;
      hitN = 1;
      bonusN = 1;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      checkOuts();
      #4 rst = 0;
      @(posedge clk);
      #1;

      // hit held low from a fresh start
      cyc(0, 1, 1, 1);
      ackCnt = 0;
      ackAt.delete();
      repeat (18) cyc(1, 1, 0, 1);
      chk("hold_acks", ackCnt, 3);
      if (ackAt.size() == 3) begin
         chk("hold_gap1", ackAt[1] - ackAt[0], G + 1);
         chk("hold_gap2", ackAt[2] - ackAt[1], G + 1);
      end
      chk("hold_over", int'(over), 1);

      // game over ignores hit and bonus, start recovers
      cyc(1, 1, 0, 0);
      cyc(1, 1, 1, 0);
      cyc(1, 1, 0, 1);
      cyc(0, 1, 0, 0);
      chk("restart_lives", int'(lives), INIT);
      chk("restart_over", int'(over), 0);

      // bonus saturation
      cyc(0, 1, 1, 1);
      repeat (10) cyc(1, 1, 1, 0);
      chk("bonus_sat", int'(lives), MAXL);

      // last life: hit and bonus together
      cyc(0, 1, 1, 1);
      cyc(1, 1, 0, 1);
      repeat (G) cyc(1, 1, 1, 1);
      cyc(1, 1, 0, 1);
      repeat (G) cyc(1, 1, 1, 1);
      chk("one_life", int'(lives), 1);
      cyc(1, 1, 0, 0);
      chk("cancel_lives", int'(lives), 1);
      chk("cancel_grace", int'(grace), 1);
      chk("cancel_ack", int'(ack), 1);

      // start and clear on the same clock
      repeat (G) cyc(1, 1, 1, 1);
      cyc(0, 0, 1, 1);
      chk("clr_wins", int'(lives), 0);

      // reset in the middle of grace
      cyc(0, 1, 1, 1);
      cyc(1, 1, 0, 1);
      cyc(1, 1, 1, 1);
      rst = 1;
      #1;
      modelReset();
      checkOuts();
      @(posedge clk);
      #1;
      checkOuts();
      #4 rst = 0;
      repeat (4) cyc(1, 1, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);

      // random play
      for (int i = 0; i < 2000; i++) begin
         bit s;
         bit c;
         bit h;
         bit b;
         s = ($urandom_range(0, 99) >= 4);
         c = ($urandom_range(0, 99) >= 2);
         h = ($urandom_range(0, 99) >= 30);
         b = ($urandom_range(0, 99) >= 25);
         cyc(s, c, h, b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
